// File: rtl/br_status_queue.sv
// Branch status queue: in-order tracker of in-flight control transfers with resolve, squash, redirect and commit.
// Optional macro BR_STATUS_QUEUE_STATS_EN adds saturating stat_commit / stat_miss counters.
package br_status_queue_pkg;
    typedef enum logic [2:0] {
        BR_BRANCH  = 3'd0,
        BR_JUMP    = 3'd1,
        BR_CALL    = 3'd2,
        BR_RET     = 3'd3,
        BR_CALLRET = 3'd4
    } BrInstType_t;
endpackage

module br_status_queue
    import br_status_queue_pkg::*;
#(
    parameter int ADDR      = 32,
    parameter int ROB_DEPTH = 64,
    parameter int DEPTH     = 8,
    parameter int ALLOC     = 2,
    parameter int ROB       = $clog2(ROB_DEPTH),
    parameter int IDX       = $clog2(DEPTH),
    parameter int TW        = $bits(BrInstType_t)
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [ALLOC-1:0]      alloc_e_,
    input  logic [ALLOC*ROB-1:0]  alloc_rob_id,
    input  logic [ALLOC*TW-1:0]   alloc_type,
    input  logic [ALLOC-1:0]      alloc_pred,
    input  logic [ALLOC*ADDR-1:0] alloc_pc,
    input  logic [ALLOC*ADDR-1:0] alloc_target,
    output logic                  busy,
    input  logic [ROB-1:0]        exe_rob_id,
    output logic                  exe_hit,
    output logic                  exe_pred,
    output logic [ADDR-1:0]       exe_target,
    input  logic                  wb_e_,
    input  logic [ROB-1:0]        wb_rob_id,
    input  logic                  wb_taken,
    input  logic [ADDR-1:0]       wb_target,
    output logic                  redirect_e_,
    output logic [ADDR-1:0]       redirect_pc,
    input  logic                  commit_e_,
    output logic                  com_valid,
    output logic [TW-1:0]         com_type,
    output logic                  com_taken,
    output logic                  com_miss,
    output logic [ADDR-1:0]       com_target,
    output logic                  com_err
`ifdef BR_STATUS_QUEUE_STATS_EN
    ,
    output logic [31:0]           stat_commit,
    output logic [31:0]           stat_miss
`endif
);

    localparam int PW = IDX + 1;
    localparam logic [PW-1:0] BUSY_TH = PW'(DEPTH - ALLOC);

    // Strobes are single-cycle, active-low and unconditional: alloc_e_ may only be
    // asserted while busy=0, wb_e_ is always accepted, commit_e_ pops only when com_valid=1.

    logic [ROB-1:0]  e_rob   [DEPTH];
    logic [TW-1:0]   e_type  [DEPTH];
    logic            e_pred  [DEPTH];
    logic [ADDR-1:0] e_pc    [DEPTH];
    logic [ADDR-1:0] e_ptgt  [DEPTH];
    logic            e_res   [DEPTH];
    logic            e_taken [DEPTH];
    logic            e_miss  [DEPTH];
    logic [ADDR-1:0] e_atgt  [DEPTH];

    logic [PW-1:0]  head, tail, count;
    logic [IDX-1:0] head_idx;
    logic           empty;
    logic [IDX-1:0] age_idx   [DEPTH];
    logic [IDX-1:0] alloc_off [ALLOC];
    logic [PW-1:0]  alloc_n;
    logic           exe_hit_c, wb_hit, wb_miss, do_pop;
    logic [IDX-1:0] exe_idx, wb_idx;
    logic [PW-1:0]  wb_age;

    assign count    = tail - head;
    assign empty    = (head == tail);
    assign busy     = (count > BUSY_TH);
    assign head_idx = head[IDX-1:0];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_idx[k] = head_idx + IDX'(k);
        end
    end

    // Scan youngest to oldest so the oldest matching entry wins.
    always_comb begin
        exe_hit_c = 1'b0;
        exe_idx   = '0;
        wb_hit    = 1'b0;
        wb_idx    = '0;
        wb_age    = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (PW'(k) < count && e_rob[age_idx[k]] == exe_rob_id) begin
                exe_hit_c = 1'b1;
                exe_idx   = age_idx[k];
            end
            if (PW'(k) < count && e_rob[age_idx[k]] == wb_rob_id) begin
                wb_hit = 1'b1;
                wb_idx = age_idx[k];
                wb_age = PW'(k);
            end
        end
    end

    assign exe_hit    = exe_hit_c;
    assign exe_pred   = exe_hit_c ? e_pred[exe_idx] : 1'b0;
    assign exe_target = exe_hit_c ? e_ptgt[exe_idx] : '0;

    always_comb begin
        wb_miss = 1'b0;
        if (!wb_e_ && wb_hit) begin
            if (e_type[wb_idx] == TW'(BR_BRANCH)) begin
                wb_miss = (wb_taken != e_pred[wb_idx]) ||
                          (wb_taken && (wb_target != e_ptgt[wb_idx]));
            end else begin
                wb_miss = (wb_target != e_ptgt[wb_idx]);
            end
        end
    end

    always_comb begin
        alloc_n = '0;
        for (int s = 0; s < ALLOC; s++) begin
            alloc_off[s] = tail[IDX-1:0] + alloc_n[IDX-1:0];
            if (!alloc_e_[s]) alloc_n = alloc_n + PW'(1);
        end
    end

    assign com_valid  = !empty && e_res[head_idx];
    assign com_type   = empty ? '0 : e_type[head_idx];
    assign com_taken  = com_valid ? e_taken[head_idx] : 1'b0;
    assign com_miss   = com_valid ? e_miss[head_idx] : 1'b0;
    assign com_target = com_valid ? e_atgt[head_idx] : '0;
    assign do_pop     = !commit_e_ && com_valid;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            head        <= '0;
            tail        <= '0;
            redirect_e_ <= 1'b1;
            redirect_pc <= '0;
            com_err     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                e_rob[i]   <= '0;
                e_type[i]  <= '0;
                e_pred[i]  <= 1'b0;
                e_pc[i]    <= '0;
                e_ptgt[i]  <= '0;
                e_res[i]   <= 1'b0;
                e_taken[i] <= 1'b0;
                e_miss[i]  <= 1'b0;
                e_atgt[i]  <= '0;
            end
        end else begin
            if (do_pop) head <= head + PW'(1);
            if (!commit_e_ && !com_valid) com_err <= 1'b1;
            redirect_e_ <= !wb_miss;
            // A squash truncates the queue just past the mispredicted entry and
            // discards whatever decode offers in the same cycle.
            if (wb_miss) begin
                tail        <= head + wb_age + PW'(1);
                redirect_pc <= wb_taken ? wb_target : e_pc[wb_idx] + ADDR'(4);
            end else begin
                tail <= tail + alloc_n;
                for (int s = 0; s < ALLOC; s++) begin
                    if (!alloc_e_[s]) begin
                        e_rob[alloc_off[s]]   <= alloc_rob_id[s*ROB +: ROB];
                        e_type[alloc_off[s]]  <= alloc_type[s*TW +: TW];
                        e_pred[alloc_off[s]]  <= alloc_pred[s];
                        e_pc[alloc_off[s]]    <= alloc_pc[s*ADDR +: ADDR];
                        e_ptgt[alloc_off[s]]  <= alloc_target[s*ADDR +: ADDR];
                        e_res[alloc_off[s]]   <= 1'b0;
                        e_taken[alloc_off[s]] <= 1'b0;
                        e_miss[alloc_off[s]]  <= 1'b0;
                        e_atgt[alloc_off[s]]  <= '0;
                    end
                end
            end
            if (!wb_e_ && wb_hit) begin
                e_res[wb_idx]   <= 1'b1;
                e_taken[wb_idx] <= wb_taken;
                e_atgt[wb_idx]  <= wb_target;
                e_miss[wb_idx]  <= wb_miss;
            end
        end
    end

`ifdef BR_STATUS_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            stat_commit <= '0;
            stat_miss   <= '0;
        end else if (do_pop) begin
            if (stat_commit != 32'hffff_ffff) stat_commit <= stat_commit + 32'd1;
            if (com_miss && stat_miss != 32'hffff_ffff) stat_miss <= stat_miss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_br_status_queue.sv
// Directed bench for br_status_queue: fill/drain, mispredict squash, flush priority, wrap, error and reset.
module tb_br_status_queue;
    import br_status_queue_pkg::*;

    localparam int ADDR = 32;
    localparam int ROB_DEPTH = 64;
    localparam int DEPTH = 8;
    localparam int ALLOC = 2;
    localparam int ROB = 6;
    localparam int TW = $bits(BrInstType_t);

    logic                  clk;
    logic                  reset_;
    logic [ALLOC-1:0]      alloc_e_;
    logic [ALLOC*ROB-1:0]  alloc_rob_id;
    logic [ALLOC*TW-1:0]   alloc_type;
    logic [ALLOC-1:0]      alloc_pred;
    logic [ALLOC*ADDR-1:0] alloc_pc;
    logic [ALLOC*ADDR-1:0] alloc_target;
    logic                  busy;
    logic [ROB-1:0]        exe_rob_id;
    logic                  exe_hit;
    logic                  exe_pred;
    logic [ADDR-1:0]       exe_target;
    logic                  wb_e_;
    logic [ROB-1:0]        wb_rob_id;
    logic                  wb_taken;
    logic [ADDR-1:0]       wb_target;
    logic                  redirect_e_;
    logic [ADDR-1:0]       redirect_pc;
    logic                  commit_e_;
    logic                  com_valid;
    logic [TW-1:0]         com_type;
    logic                  com_taken;
    logic                  com_miss;
    logic [ADDR-1:0]       com_target;
    logic                  com_err;
`ifdef BR_STATUS_QUEUE_STATS_EN
    logic [31:0]           stat_commit;
    logic [31:0]           stat_miss;
`endif

    br_status_queue #(
        .ADDR(ADDR), .ROB_DEPTH(ROB_DEPTH), .DEPTH(DEPTH), .ALLOC(ALLOC)
    ) dut (
        .clk(clk), .reset_(reset_),
        .alloc_e_(alloc_e_), .alloc_rob_id(alloc_rob_id), .alloc_type(alloc_type),
        .alloc_pred(alloc_pred), .alloc_pc(alloc_pc), .alloc_target(alloc_target),
        .busy(busy),
        .exe_rob_id(exe_rob_id), .exe_hit(exe_hit), .exe_pred(exe_pred), .exe_target(exe_target),
        .wb_e_(wb_e_), .wb_rob_id(wb_rob_id), .wb_taken(wb_taken), .wb_target(wb_target),
        .redirect_e_(redirect_e_), .redirect_pc(redirect_pc),
        .commit_e_(commit_e_), .com_valid(com_valid), .com_type(com_type),
        .com_taken(com_taken), .com_miss(com_miss), .com_target(com_target),
        .com_err(com_err)
`ifdef BR_STATUS_QUEUE_STATS_EN
        , .stat_commit(stat_commit), .stat_miss(stat_miss)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        alloc_e_  = '1;
        wb_e_     = 1'b1;
        commit_e_ = 1'b1;
        #1;
    endtask

    task automatic set_slot(input int s, input logic [ROB-1:0] rob, input BrInstType_t t,
                            input logic pred, input logic [ADDR-1:0] pc, input logic [ADDR-1:0] tgt);
        alloc_e_[s]                = 1'b0;
        alloc_rob_id[s*ROB +: ROB] = rob;
        alloc_type[s*TW +: TW]     = t;
        alloc_pred[s]              = pred;
        alloc_pc[s*ADDR +: ADDR]   = pc;
        alloc_target[s*ADDR +: ADDR] = tgt;
    endtask

    task automatic set_wb(input logic [ROB-1:0] rob, input logic taken, input logic [ADDR-1:0] tgt);
        wb_e_     = 1'b0;
        wb_rob_id = rob;
        wb_taken  = taken;
        wb_target = tgt;
    endtask

    task automatic alloc_go();
        check("alloc_while_busy", busy, 1'b0);
        tick();
    endtask

    task automatic commit_go();
        commit_e_ = 1'b0;
        tick();
    endtask

    task automatic lookup(input string tag, input logic [ROB-1:0] rob, input logic exp_hit,
                          input logic [ADDR-1:0] exp_tgt);
        exe_rob_id = rob;
        #1;
        check({tag, "_hit"}, exe_hit, exp_hit);
        if (exp_hit) check({tag, "_tgt"}, exe_target, exp_tgt);
    endtask

    initial begin
        reset_       = 1'b0;
        alloc_e_     = '1;
        alloc_rob_id = '0;
        alloc_type   = '0;
        alloc_pred   = '0;
        alloc_pc     = '0;
        alloc_target = '0;
        exe_rob_id   = '0;
        wb_e_        = 1'b1;
        wb_rob_id    = '0;
        wb_taken     = 1'b0;
        wb_target    = '0;
        commit_e_    = 1'b1;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_exe_hit", exe_hit, 1'b0);
        check("rst_redirect_e_", redirect_e_, 1'b1);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_com_valid", com_valid, 1'b0);
        check("rst_com_err", com_err, 1'b0);
        check("rst_com_target", com_target, 32'h0);
        @(negedge clk);
        reset_ = 1'b1;

        // fill to full, resolve, drain
        for (int c = 0; c < 4; c++) begin
            set_slot(0, ROB'(2*c),   BR_BRANCH, 1'b0, 32'h1000 + 32'(8*c), 32'h2000 + 32'(8*c));
            set_slot(1, ROB'(2*c+1), BR_BRANCH, 1'b0, 32'h1004 + 32'(8*c), 32'h2004 + 32'(8*c));
            alloc_go();
        end
        check("fill_busy", busy, 1'b1);
        check("fill_head_unresolved", com_valid, 1'b0);
        lookup("fill_exe_rob3", 6'd3, 1'b1, 32'h200c);
        check("fill_exe_pred", exe_pred, 1'b0);
        for (int r = 0; r < 8; r++) begin
            set_wb(ROB'(r), 1'b0, 32'h0);
            tick();
            check("fill_wb_no_redirect", redirect_e_, 1'b1);
        end
        for (int r = 0; r < 8; r++) begin
            check("drain_com_valid", com_valid, 1'b1);
            check("drain_com_miss", com_miss, 1'b0);
            commit_go();
        end
        check("drain_empty", com_valid, 1'b0);
        check("drain_busy", busy, 1'b0);
        check("drain_com_err", com_err, 1'b0);
        lookup("drain_exe_rob0", 6'd0, 1'b0, 32'h0);

        // not-taken prediction resolved taken squashes three younger entries
        set_slot(0, 6'd5, BR_BRANCH, 1'b0, 32'h100, 32'h104);
        set_slot(1, 6'd6, BR_BRANCH, 1'b0, 32'h104, 32'h108);
        alloc_go();
        set_slot(0, 6'd7, BR_BRANCH, 1'b0, 32'h108, 32'h10c);
        set_slot(1, 6'd8, BR_BRANCH, 1'b0, 32'h10c, 32'h110);
        alloc_go();
        set_wb(6'd5, 1'b1, 32'h180);
        tick();
        check("sq_redirect_e_", redirect_e_, 1'b0);
        check("sq_redirect_pc", redirect_pc, 32'h180);
        lookup("sq_rob5", 6'd5, 1'b1, 32'h104);
        lookup("sq_rob6", 6'd6, 1'b0, 32'h0);
        lookup("sq_rob8", 6'd8, 1'b0, 32'h0);
        check("sq_com_valid", com_valid, 1'b1);
        check("sq_com_taken", com_taken, 1'b1);
        check("sq_com_miss", com_miss, 1'b1);
        check("sq_com_target", com_target, 32'h180);
        tick();
        check("sq_redirect_one_cycle", redirect_e_, 1'b1);
        commit_go();
        check("sq_empty", com_valid, 1'b0);

        // flush in the same cycle as allocate drops the allocation
        set_slot(0, 6'd11, BR_BRANCH, 1'b0, 32'h600, 32'h604);
        alloc_go();
        set_wb(6'd11, 1'b1, 32'h700);
        set_slot(0, 6'd12, BR_BRANCH, 1'b0, 32'h604, 32'h608);
        set_slot(1, 6'd13, BR_BRANCH, 1'b0, 32'h608, 32'h60c);
        alloc_go();
        check("fa_redirect_pc", redirect_pc, 32'h700);
        lookup("fa_rob12", 6'd12, 1'b0, 32'h0);
        lookup("fa_rob13", 6'd13, 1'b0, 32'h0);
        commit_go();
        check("fa_empty", com_valid, 1'b0);

        // taken prediction resolved not-taken redirects to pc+4
        set_slot(0, 6'd7, BR_BRANCH, 1'b1, 32'h300, 32'h200);
        alloc_go();
        set_wb(6'd7, 1'b0, 32'h999);
        tick();
        check("nt_redirect_e_", redirect_e_, 1'b0);
        check("nt_redirect_pc", redirect_pc, 32'h304);
        check("nt_com_miss", com_miss, 1'b1);
        check("nt_com_taken", com_taken, 1'b0);
        commit_go();

        // jump: correct target, then wrong target
        set_slot(0, 6'd9, BR_JUMP, 1'b1, 32'h500, 32'h400);
        alloc_go();
        set_wb(6'd9, 1'b1, 32'h400);
        tick();
        check("jmp_ok_redirect_e_", redirect_e_, 1'b1);
        check("jmp_ok_com_miss", com_miss, 1'b0);
        check("jmp_ok_com_type", com_type, BR_JUMP);
        commit_go();
        set_slot(0, 6'd10, BR_JUMP, 1'b1, 32'h504, 32'h400);
        alloc_go();
        set_wb(6'd10, 1'b1, 32'h404);
        tick();
        check("jmp_bad_redirect_e_", redirect_e_, 1'b0);
        check("jmp_bad_redirect_pc", redirect_pc, 32'h404);
        check("jmp_bad_com_miss", com_miss, 1'b1);
        commit_go();

        // commit of resolved head together with a flush of the next entry
        set_slot(0, 6'd20, BR_BRANCH, 1'b0, 32'h800, 32'h804);
        set_slot(1, 6'd21, BR_BRANCH, 1'b0, 32'h804, 32'h808);
        alloc_go();
        set_slot(0, 6'd22, BR_BRANCH, 1'b0, 32'h808, 32'h80c);
        alloc_go();
        set_wb(6'd20, 1'b0, 32'h0);
        tick();
        set_wb(6'd21, 1'b1, 32'h900);
        commit_e_ = 1'b0;
        tick();
        check("cf_com_err", com_err, 1'b0);
        check("cf_redirect_pc", redirect_pc, 32'h900);
        lookup("cf_rob20", 6'd20, 1'b0, 32'h0);
        lookup("cf_rob21", 6'd21, 1'b1, 32'h808);
        lookup("cf_rob22", 6'd22, 1'b0, 32'h0);
        check("cf_com_miss", com_miss, 1'b1);
        check("cf_com_target", com_target, 32'h900);
        commit_go();
        check("cf_empty", com_valid, 1'b0);

        // wrap: 40 entries push the pointers around more than twice
        for (int it = 0; it < 20; it++) begin
            for (int s = 0; s < 2; s++) begin
                set_slot(s, ROB'(24 + 2*it + s), BR_BRANCH, 1'b1,
                         32'h4000 + 32'(4*(24 + 2*it + s)), 32'h8000 + 32'(16*(24 + 2*it + s)));
                exp_q.push_back(32'h8000 + 32'(16*(24 + 2*it + s)));
            end
            alloc_go();
            lookup("wr_exe_s0", ROB'(24 + 2*it), 1'b1, 32'h8000 + 32'(16*(24 + 2*it)));
            lookup("wr_exe_s1", ROB'(25 + 2*it), 1'b1, 32'h8000 + 32'(16*(25 + 2*it)));
            for (int s = 0; s < 2; s++) begin
                set_wb(ROB'(24 + 2*it + s), 1'b1, 32'h8000 + 32'(16*(24 + 2*it + s)));
                tick();
            end
            check("wr_no_redirect", redirect_e_, 1'b1);
            for (int s = 0; s < 2; s++) begin
                check("wr_com_valid", com_valid, 1'b1);
                check("wr_com_target", com_target, exp_q.pop_front());
                check("wr_com_miss", com_miss, 1'b0);
                commit_go();
            end
            check("wr_empty", com_valid, 1'b0);
            check("wr_busy", busy, 1'b0);
        end

        // commit on an unresolved head
        set_slot(0, 6'd40, BR_BRANCH, 1'b0, 32'ha00, 32'ha04);
        alloc_go();
        commit_go();
        check("err_com_err", com_err, 1'b1);
        check("err_com_valid", com_valid, 1'b0);
        lookup("err_head_kept", 6'd40, 1'b1, 32'ha04);
        set_wb(6'd40, 1'b0, 32'h0);
        tick();
        check("err_head_resolved", com_valid, 1'b1);

        // reset mid-operation with a redirect pending
        set_slot(0, 6'd41, BR_BRANCH, 1'b0, 32'ha04, 32'ha08);
        alloc_go();
        set_wb(6'd41, 1'b1, 32'hb00);
        tick();
        check("mr_redirect_pending", redirect_e_, 1'b0);
        reset_ = 1'b0;
        #1;
        check("mr_redirect_e_", redirect_e_, 1'b1);
        check("mr_redirect_pc", redirect_pc, 32'h0);
        check("mr_com_err", com_err, 1'b0);
        check("mr_com_valid", com_valid, 1'b0);
        check("mr_busy", busy, 1'b0);
        lookup("mr_rob40", 6'd40, 1'b0, 32'h0);
        @(negedge clk);
        reset_ = 1'b1;

        // writeback of the head in the same cycle as its commit
        set_slot(0, 6'd50, BR_BRANCH, 1'b0, 32'hc00, 32'hc04);
        alloc_go();
        set_wb(6'd50, 1'b0, 32'h0);
        commit_e_ = 1'b0;
        tick();
        check("wc_com_err", com_err, 1'b1);
        check("wc_com_valid", com_valid, 1'b1);
        lookup("wc_rob50", 6'd50, 1'b1, 32'hc04);
        commit_go();
        check("wc_empty", com_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
